// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide over WIDTH cycles,
// with sign handling around an unsigned-magnitude datapath.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [3:0]       WA3In,
    input  logic             Abort,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       MCycleWA3
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   hi_r, lo_r, b_r;
    logic               sign_q_r, sign_r_r, div_zero_r;
    logic [WIDTH-1:0]   result1_r, result2_r;
    logic               busy_r, done_r;
    logic [3:0]         wa3_r;

    logic               launch_s, last_s, sign1_s, sign2_s;
    logic [WIDTH-1:0]   mag1_s, mag2_s, hi_next_s, lo_next_s, fin1_s, fin2_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [2*WIDTH-1:0] prod_s;

    assign launch_s = (state_r == S_IDLE) && Start && !Abort;
    assign last_s   = (state_r == S_COMPUTE) && !Abort && (cnt_r == CNT_W'(WIDTH-1));

    // Next-state selection for the IDLE/COMPUTE/DONE sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (launch_s) state_next_s = S_COMPUTE;
                else          state_next_s = S_IDLE;
            end
            S_COMPUTE: begin
                if (Abort)       state_next_s = S_IDLE;
                else if (last_s) state_next_s = S_DONE;
                else             state_next_s = S_COMPUTE;
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Operand magnitudes and signs for the launch edge (odd ops are unsigned)
    always_comb begin
        sign1_s = !MCycleOp[0] && Operand1[WIDTH-1];
        sign2_s = !MCycleOp[0] && Operand2[WIDTH-1];
        mag1_s  = sign1_s ? neg_w(Operand1) : Operand1;
        mag2_s  = sign2_s ? neg_w(Operand2) : Operand2;
    end

    // One iteration: hi/lo hold accumulator/multiplier for mul, remainder/quotient for div
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, b_r};
        if (op_r[1]) begin
            if (!div_diff_s[WIDTH+1]) begin
                hi_next_s = div_diff_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_next_s = div_shift_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next_s = mul_sum_s[WIDTH:1];
            lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the final iteration's values; a zero divisor forces an all-ones quotient
    always_comb begin
        prod_s = sign_q_r ? neg_2w({hi_next_s, lo_next_s}) : {hi_next_s, lo_next_s};
        if (op_r[1]) begin
            if (div_zero_r)    fin1_s = {WIDTH{1'b1}};
            else if (sign_q_r) fin1_s = neg_w(lo_next_s);
            else               fin1_s = lo_next_s;
            fin2_s = sign_r_r ? neg_w(hi_next_s) : hi_next_s;
        end else begin
            fin1_s = prod_s[WIDTH-1:0];
            fin2_s = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // Control state and registered status outputs
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == S_COMPUTE);
            done_r  <= (state_next_s == S_DONE);
        end
    end

    // Datapath: latch on launch, iterate in COMPUTE, capture results on the last iteration
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_r      <= {CNT_W{1'b0}};
            op_r       <= 2'b00;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            sign_q_r   <= 1'b0;
            sign_r_r   <= 1'b0;
            div_zero_r <= 1'b0;
            result1_r  <= {WIDTH{1'b0}};
            result2_r  <= {WIDTH{1'b0}};
            wa3_r      <= 4'h0;
        end else if (launch_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            op_r       <= MCycleOp;
            wa3_r      <= WA3In;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= MCycleOp[1] ? mag1_s : mag2_s;
            b_r        <= MCycleOp[1] ? mag2_s : mag1_s;
            sign_q_r   <= sign1_s ^ sign2_s;
            sign_r_r   <= sign1_s;
            div_zero_r <= (Operand2 == {WIDTH{1'b0}});
        end else if ((state_r == S_COMPUTE) && !Abort) begin
            hi_r  <= hi_next_s;
            lo_r  <= lo_next_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_s) begin
                result1_r <= fin1_s;
                result2_r <= fin2_s;
            end
        end
    end

    assign Result1   = result1_r;
    assign Result2   = result2_r;
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign MCycleWA3 = wa3_r;
endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: directed corner cases plus random operations
// checked against a 64-bit arithmetic reference model.
module tb_mcycle_unit;
    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic [1:0]    MCycleOp = 2'b00;
    logic [W-1:0]  Operand1 = '0;
    logic [W-1:0]  Operand2 = '0;
    logic [3:0]    WA3In = 4'h0;
    logic [W-1:0]  Result1, Result2;
    logic          Busy, Done;
    logic [3:0]    MCycleWA3;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2), .WA3In(WA3In), .Abort(Abort),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done),
        .MCycleWA3(MCycleWA3)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [3:0]   wa;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] last_r1 = '0;
    logic [W-1:0] last_r2 = '0;
    logic [3:0]   last_wa = 4'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating division, zero-divisor rule
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r1, output logic [W-1:0] r2);
        longint       sa, sb;
        logic [63:0]  t, u;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: begin t = sa * sb; r1 = t[31:0]; r2 = t[63:32]; end
            2'd1: begin t = {32'h0, a} * {32'h0, b}; r1 = t[31:0]; r2 = t[63:32]; end
            default: begin
                if (b == '0) begin
                    r1 = '1;
                    r2 = a;
                end else if (op == 2'd2) begin
                    t = sa / sb; u = sa % sb;
                    r1 = t[31:0]; r2 = u[31:0];
                end else begin
                    r1 = a / b; r2 = a % b;
                end
            end
        endcase
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (Done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {63'd0, Done}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("result1", Result1, e.r1);
                chk("result2", Result2, e.r2);
                chk("wa3_at_done", MCycleWA3, e.wa);
            end
        end
    end

    // inj: 0 none, 1 Start at COMPUTE cycle 10, 2 Abort at cycle 12, 3 reset at cycle 20
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] wa, input int inj);
        exp_t e;
        int   busy_bad = 0;
        int   done_bad = 0;
        bit   stopped = 1'b0;
        model(op, a, b, e.r1, e.r2);
        e.wa = wa;
        @(negedge CLK);
        MCycleOp = op; Operand1 = a; Operand2 = b; WA3In = wa; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom;
        if (inj < 2) sb_q.push_back(e);
        chk("wa3_latched", MCycleWA3, wa);
        last_wa = wa;
        for (int i = 1; i <= W && !stopped; i++) begin
            if (Busy !== 1'b1 || Done !== 1'b0) busy_bad++;
            if (inj == 1 && i == 10) begin
                Start = 1'b1; MCycleOp = ~op; WA3In = ~wa;
            end
            if (inj == 2 && i == 12) begin
                Abort = 1'b1; stopped = 1'b1;
            end
            if (inj == 3 && i == 20) begin
                RESETn = 1'b0;
                #1;
                chk("reset_results", {Result1, Result2}, 64'd0);
                chk("reset_flags", {58'd0, Busy, Done, MCycleWA3}, 64'd0);
                stopped = 1'b1;
                last_r1 = '0; last_r2 = '0; last_wa = 4'h0;
            end
            @(negedge CLK);
            Start = 1'b0; Abort = 1'b0; RESETn = 1'b1;
        end
        chk("busy_window", busy_bad, 0);
        if (!stopped) begin
            chk("done_at_w_plus_1", {62'd0, Busy, Done}, 64'd1);
            last_r1 = e.r1; last_r2 = e.r2;
            @(negedge CLK);
            chk("done_one_cycle", {62'd0, Busy, Done}, 64'd0);
            repeat (2) @(negedge CLK);
            chk("result_hold", {Result1, Result2}, {e.r1, e.r2});
            chk("wa3_hold", MCycleWA3, wa);
        end else begin
            chk("busy_dropped", Busy, 0);
            repeat (W + 4) begin
                if (Done !== 1'b0) done_bad++;
                @(negedge CLK);
            end
            chk("no_done_after_cancel", done_bad, 0);
            chk("results_unchanged", {Result1, Result2}, {last_r1, last_r2});
            chk("wa3_after_cancel", MCycleWA3, last_wa);
        end
    endtask

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, b;
        repeat (2) @(negedge CLK);
        chk("reset_state", {Result1, Result2}, 64'd0);
        chk("reset_status", {58'd0, Busy, Done, MCycleWA3}, 64'd0);
        RESETn = 1'b1;

        run_op(2'd1, 32'd7, 32'd6, 4'h5, 0);
        run_op(2'd0, -32'sd3, 32'd5, 4'h1, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2, 0);
        run_op(2'd2, -32'sd7, 32'd2, 4'h3, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 4'h4, 0);
        run_op(2'd3, 32'd100, 32'd0, 4'h6, 0);
        run_op(2'd2, -32'sd9, 32'd0, 4'h7, 0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 4'h8, 0);
        run_op(2'd3, 32'd1000, 32'd7, 4'h9, 1);
        run_op(2'd0, 32'd12, 32'd12, 4'hA, 2);
        run_op(2'd2, 32'd50, -32'sd6, 4'hB, 3);
        run_op(2'd2, 32'd50, -32'sd6, 4'hC, 0);

        @(negedge CLK);
        Start = 1'b1; Abort = 1'b1;
        @(negedge CLK);
        Start = 1'b0; Abort = 1'b0;
        chk("start_with_abort_idle", {62'd0, Busy, Done}, 64'd0);
        chk("start_with_abort_wa3", MCycleWA3, 4'hC);

        for (int k = 0; k < 24; k++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = '0;
                default: a = $urandom;
            endcase
            run_op(op, a, b, 4'($urandom_range(0, 15)), 0);
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
